// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch mm:ss sequencer, run/pause FSM, adjust logic and display enables
// Optional button debounce: define STOPWATCH_DEBOUNCE_EN.
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 100_000_000,
    parameter int FAST_DIV        = 200_000,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pause_btn,
    input  logic       clear_btn,
    input  logic       sel_sw,
    input  logic       adj_sw,
    output logic [5:0] min,
    output logic [5:0] sec,
    output logic       sel,
    output logic       adj,
    output logic       fast_tick,
    output logic       blink
);
    localparam int HALF_HZ = CLK_HZ / 2;
    localparam int SEC_W   = $clog2(CLK_HZ + 1);
    localparam int HALF_W  = $clog2(HALF_HZ + 1);
    localparam int FAST_W  = $clog2(FAST_DIV + 1);
    localparam logic [SEC_W-1:0]  SEC_TC  = SEC_W'(CLK_HZ - 1);
    localparam logic [HALF_W-1:0] HALF_TC = HALF_W'(HALF_HZ - 1);
    localparam logic [FAST_W-1:0] FAST_TC = FAST_W'(FAST_DIV - 1);

    typedef enum logic {S_PAUSED, S_RUN} state_t;

    state_t            state_q, state_d;
    logic [3:0]        sync1_q, sync2_q;
    logic [1:0]        btn_lvl, btn_prev_q, btn_evt;
    logic [5:0]        min_q, min_d, sec_q, sec_d;
    logic [SEC_W-1:0]  sec_div_q, sec_div_d;
    logic [HALF_W-1:0] adj_div_q, adj_div_d, blink_cnt_q, blink_cnt_d;
    logic [FAST_W-1:0] fast_cnt_q, fast_cnt_d;
    logic              fast_tick_q, fast_tick_d, blink_q, blink_d;
    logic              sec_tick, adj_tick;

    function automatic logic [5:0] wrap_inc(input logic [5:0] v);
        return (v == 6'd59) ? 6'd0 : v + 6'd1;
    endfunction

    // Bit order of the synchronizer vector: {adj, sel, clear, pause}
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= {adj_sw, sel_sw, clear_btn, pause_btn};
            sync2_q <= sync1_q;
        end
    end

    assign sel = sync2_q[2];
    assign adj = sync2_q[3];

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_TC = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      db_lvl_q, db_lvl_d;
    logic [DB_W-1:0] db_cnt_q [2];
    logic [DB_W-1:0] db_cnt_d [2];

    // Any cycle where the synchronized level matches the held level restarts the count.
    always_comb begin
        db_lvl_d = db_lvl_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_TC) begin
                    db_lvl_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            db_lvl_q <= '0;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= '0;
        end else begin
            db_lvl_q <= db_lvl_d;
            for (int i = 0; i < 2; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    assign btn_lvl = db_lvl_q;
`else
    assign btn_lvl = sync2_q[1:0];
`endif

    assign btn_evt = btn_lvl & ~btn_prev_q;

    always_comb begin
        state_d   = state_q;
        min_d     = min_q;
        sec_d     = sec_q;
        sec_div_d = sec_div_q;
        adj_div_d = adj_div_q;
        sec_tick  = 1'b0;
        adj_tick  = 1'b0;

        // Each divider is held at zero while the other mode owns the count,
        // which gives the restart on entering and leaving adjust.
        if (adj) begin
            sec_div_d = '0;
            adj_tick  = (adj_div_q == HALF_TC);
            adj_div_d = adj_tick ? '0 : adj_div_q + 1'b1;
        end else begin
            adj_div_d = '0;
            if (state_q == S_RUN) begin
                sec_tick  = (sec_div_q == SEC_TC);
                sec_div_d = sec_tick ? '0 : sec_div_q + 1'b1;
            end
        end

        if (adj_tick) begin
            if (sel) sec_d = wrap_inc(sec_q);
            else     min_d = wrap_inc(min_q);
        end else if (sec_tick) begin
            sec_d = wrap_inc(sec_q);
            if (sec_q == 6'd59) min_d = wrap_inc(min_q);
        end

        if (btn_evt[0]) state_d = (state_q == S_RUN) ? S_PAUSED : S_RUN;

        if (btn_evt[1]) begin
            state_d   = S_PAUSED;
            min_d     = '0;
            sec_d     = '0;
            sec_div_d = '0;
            adj_div_d = '0;
        end
    end

    always_comb begin
        fast_tick_d = (fast_cnt_q == FAST_TC);
        fast_cnt_d  = fast_tick_d ? '0 : fast_cnt_q + 1'b1;
        blink_d     = blink_q ^ (blink_cnt_q == HALF_TC);
        blink_cnt_d = (blink_cnt_q == HALF_TC) ? '0 : blink_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_PAUSED;
            btn_prev_q  <= '0;
            min_q       <= '0;
            sec_q       <= '0;
            sec_div_q   <= '0;
            adj_div_q   <= '0;
            fast_cnt_q  <= '0;
            fast_tick_q <= 1'b0;
            blink_cnt_q <= '0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            btn_prev_q  <= btn_lvl;
            min_q       <= min_d;
            sec_q       <= sec_d;
            sec_div_q   <= sec_div_d;
            adj_div_q   <= adj_div_d;
            fast_cnt_q  <= fast_cnt_d;
            fast_tick_q <= fast_tick_d;
            blink_cnt_q <= blink_cnt_d;
            blink_q     <= blink_d;
        end
    end

    assign min       = min_q;
    assign sec       = sec_q;
    assign fast_tick = fast_tick_q;
    assign blink     = blink_q;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - self-checking bench for stopwatch_ctrl (CLK_HZ=8, FAST_DIV=2)
module tb_stopwatch_ctrl;
    logic       clk = 1'b0;
    logic       rst, pause_btn, clear_btn, sel_sw, adj_sw;
    logic [5:0] min, sec;
    logic       sel, adj, fast_tick, blink;

    int    n_cmp = 0;
    int    n_bad = 0;
    string exp_tag_q[$];
    int    exp_val_q[$];

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ(8),
        .FAST_DIV(2),
        .DEBOUNCE_CYCLES(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pause_btn(pause_btn),
        .clear_btn(clear_btn),
        .sel_sw(sel_sw),
        .adj_sw(adj_sw),
        .min(min),
        .sec(sec),
        .sel(sel),
        .adj(adj),
        .fast_tick(fast_tick),
        .blink(blink)
    );

    task automatic check_val(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected mm:ss encoded as mm*100+ss
    task automatic expect_mmss(input string tag, input int m, input int s);
        exp_tag_q.push_back(tag);
        exp_val_q.push_back(m * 100 + s);
    endtask

    task automatic compare_mmss();
        if (exp_val_q.size() == 0) begin
            check_val("scoreboard_underflow", 1, 0);
        end else begin
            check_val(exp_tag_q.pop_front(), int'(min) * 100 + int'(sec), exp_val_q.pop_front());
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns on the edge where the toggle lands (no-debounce latency)
    task automatic press_pause();
        pause_btn = 1'b1;
        cycles(1);
        pause_btn = 1'b0;
        cycles(2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_min"}, int'(min), 0);
        check_val({tag, "_sec"}, int'(sec), 0);
        check_val({tag, "_sel"}, int'(sel), 0);
        check_val({tag, "_adj"}, int'(adj), 0);
        check_val({tag, "_fast_tick"}, int'(fast_tick), 0);
        check_val({tag, "_blink"}, int'(blink), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; pause_btn = 1'b0; clear_btn = 1'b0; sel_sw = 1'b0; adj_sw = 1'b0;
        cycles(3);
        check_reset_outputs("reset");
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            cycles(1);
            check_val("fast_tick", int'(fast_tick), (k % 2 == 0) ? 1 : 0);
            check_val("blink", int'(blink), (k / 4) % 2);
        end
        expect_mmss("idle_40", 0, 0);
        compare_mmss();

`ifdef STOPWATCH_DEBOUNCE_EN
        expect_mmss("glitch_no_toggle", 0, 0);
        pause_btn = 1'b1;
        cycles(3);
        pause_btn = 1'b0;
        cycles(30);
        compare_mmss();

        expect_mmss("press_before_first_tick", 0, 0);
        expect_mmss("press_first_tick", 0, 1);
        expect_mmss("press_still_running", 0, 2);
        pause_btn = 1'b1;
        cycles(6);
        pause_btn = 1'b0;
        cycles(9);
        compare_mmss();
        cycles(1);
        compare_mmss();
        cycles(8);
        compare_mmss();
`else
        expect_mmss("run_487", 1, 0);
        expect_mmss("run_488", 1, 1);
        press_pause();
        cycles(487);
        compare_mmss();
        cycles(1);
        compare_mmss();

        expect_mmss("paused_hold", 1, 1);
        press_pause();
        cycles(20);
        compare_mmss();

        expect_mmss("adj_sec_59", 1, 59);
        expect_mmss("adj_sec_wrap", 1, 0);
        expect_mmss("adj_sec_59_again", 1, 59);
        expect_mmss("adj_min_first", 2, 59);
        expect_mmss("adj_min_hold", 2, 59);
        expect_mmss("adj_min_second", 3, 59);
        expect_mmss("adj_min_59", 59, 59);
        sel_sw = 1'b1;
        adj_sw = 1'b1;
        cycles(2);
        cycles(4 * 58);
        compare_mmss();
        cycles(4);
        compare_mmss();
        cycles(4 * 59);
        compare_mmss();
        sel_sw = 1'b0;
        cycles(4);
        compare_mmss();
        cycles(3);
        compare_mmss();
        cycles(1);
        compare_mmss();
        cycles(4 * 56);
        compare_mmss();

        expect_mmss("adj_off_paused", 59, 59);
        adj_sw = 1'b0;
        cycles(6);
        compare_mmss();

        expect_mmss("wrap_before", 59, 59);
        expect_mmss("wrap_full", 0, 0);
        press_pause();
        cycles(7);
        compare_mmss();
        cycles(1);
        compare_mmss();

        expect_mmss("run_to_5", 0, 5);
        expect_mmss("clear_and_pause", 0, 0);
        expect_mmss("clear_stays_paused", 0, 0);
        cycles(40);
        compare_mmss();
        clear_btn = 1'b1;
        pause_btn = 1'b1;
        cycles(1);
        clear_btn = 1'b0;
        pause_btn = 1'b0;
        cycles(2);
        compare_mmss();
        cycles(40);
        compare_mmss();

        expect_mmss("run_adj_mid", 2, 0);
        expect_mmss("run_adj_last", 3, 0);
        expect_mmss("resume_before_tick", 3, 0);
        expect_mmss("resume_tick", 3, 1);
        press_pause();
        cycles(3);
        adj_sw = 1'b1;
        cycles(12);
        adj_sw = 1'b0;
        cycles(1);
        compare_mmss();
        cycles(1);
        compare_mmss();
        cycles(7);
        compare_mmss();
        cycles(1);
        compare_mmss();

        sel_sw = 1'b1;
        cycles(3);
        check_val("sel_sync", int'(sel), 1);
        expect_mmss("mid_reset", 0, 0);
        expect_mmss("after_reset_paused", 0, 0);
        rst = 1'b1;
        cycles(1);
        check_reset_outputs("mid_reset");
        compare_mmss();
        rst = 1'b0;
        cycles(10);
        compare_mmss();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch minutes:seconds datapath. Owns the min/sec count registers, the run/pause state machine, the adjust-mode increment logic and the clock-enable generators that pace the 7-segment display multiplexer and its adjust blink. Sits between the debounced board buttons/switches and the display driver, which consumes `min`, `sec`, `sel`, `adj` and the generated enables.

## Interface
- `CLK_HZ`, 100_000_000: input clock frequency; 1 Hz period in cycles.
- `FAST_DIV`, 200_000: cycles per display-multiplex enable pulse.
- `DEBOUNCE_CYCLES`, 1_000_000: stable-input cycles required (debounce build only).
- `clk`  in  1  master clock; all logic on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pause_btn`  in  1  raw button; each press toggles RUN/PAUSED.
- `clear_btn`  in  1  raw button; each press clears count to 00:00.
- `sel_sw`  in  1  raw switch; 1 = seconds field, 0 = minutes field.
- `adj_sw`  in  1  raw switch; 1 = adjust mode.
- `min`  out  6  minutes count, 0..59.
- `sec`  out  6  seconds count, 0..59.
- `sel`  out  1  synchronized `sel_sw`.
- `adj`  out  1  synchronized `adj_sw`.
- `fast_tick`  out  1  one-cycle pulse every `FAST_DIV` cycles.
- `blink`  out  1  square wave, toggles every `CLK_HZ/2` cycles.

## Operation
- Inputs: every raw input passes a 2-flop synchronizer; `sel`/`adj` are the second-stage outputs. Buttons then go through rising-edge detection to one-cycle `pause_evt`/`clear_evt`.
- States: PAUSED (reset state), RUN. `pause_evt` toggles. `clear_evt` forces PAUSED, zeroes `min`, `sec` and the 1 Hz / adjust dividers; a simultaneous `pause_evt` is ignored.
- 1 Hz divider: counts 0..CLK_HZ-1 only when RUN and `adj`=0; holds otherwise; cleared on entering or leaving adjust. Terminal count produces `sec_tick`.
- Normal count on `sec_tick`: sec+1; sec 59 -> 0 with min+1; min 59 and sec 59 -> 00:00 (wrap, no saturation).
- Adjust (`adj`=1, either state): adjust divider counts 0..CLK_HZ/2-1; on terminal count the field chosen by `sel` increments, 59 -> 0, no carry into the other field. RUN/PAUSED state is preserved and resumes when `adj` falls.
- `sel` change during adjust: next adjust tick applies to the new field; divider not restarted.
- `fast_tick` and `blink` free-run in all states, reset only by `rst`.
- All arithmetic in 6-bit fields; values above 59 unreachable.

## Timing
- Reset values: `min`=0, `sec`=0, `sel`=0, `adj`=0, `fast_tick`=0, `blink`=0, state PAUSED, all dividers and synchronizers 0.
- Button latency (no debounce): raw rise before edge 1 -> sync stage 2 high after edge 2 -> state/count updated at edge 3.
- First `sec_tick` after entering RUN: `CLK_HZ` cycles after the toggling edge; `sec` increments on that edge.
- First adjust increment: `CLK_HZ/2` cycles after `adj` rises.
- `fast_tick` period exactly `FAST_DIV` cycles, first pulse at cycle `FAST_DIV` after reset release.
- `rst` mid-operation: all registers return to reset values on the same edge; no pending events survive.

## Configuration
- `STOPWATCH_DEBOUNCE_EN` defined: each button adds a counter after the synchronizer; the debounced level changes only after the synchronized level differs from it for `DEBOUNCE_CYCLES` consecutive cycles (counter resets on any bounce). Edge detection runs on the debounced level; latency grows by `DEBOUNCE_CYCLES`.
- Undefined: no debounce counters; edge detection directly on synchronizer output; `DEBOUNCE_CYCLES` unused.

## Test plan
(CLK_HZ=8, FAST_DIV=2, debounce undefined unless noted.)
- Reset then idle 40 cycles -> `min`=0, `sec`=0, PAUSED; `fast_tick` pulses every 2 cycles; `blink` toggles every 4.
- Pulse `pause_btn`, run 8*61 cycles -> count 00:00 -> 01:01; preset 59:59 and one `sec_tick` -> 00:00.
- RUN at 00:05, pulse `clear_btn` and `pause_btn` same cycle -> 00:00, PAUSED, no further increments.
- PAUSED, `adj`=1 `sel`=1 for 4*60 cycles -> sec wraps 59 -> 0 with `min` unchanged; `sel`=0 -> min increments every 4 cycles.
- RUN, assert `adj` for 12 cycles then drop -> normal counting resumes, next `sec_tick` 8 cycles after `adj` falls.
- `STOPWATCH_DEBOUNCE_EN`, DEBOUNCE_CYCLES=5: 3-cycle glitch on `pause_btn` -> no toggle; 6-cycle press -> exactly one toggle.
